// File: rtl/fir_pkg.sv
// fir_pkg: shared types and default widths for the serial-MAC FIR engine.
// Holds the controller state encoding, default sample/coefficient/tap sizes,
// and the accumulator width derivation used by the engine and its bench.
`timescale 1ns/1ps
package fir_pkg;

  localparam int DWIDTH = 8;
  localparam int CWIDTH = 8;
  localparam int NTAPS  = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    MAC,
    OUT
  } fir_state_e;

  // Product width plus enough guard bits to sum NTAPS worst-case products.
  function automatic int calc_awidth(input int dw, input int cw, input int nt);
    return dw + cw + $clog2(nt);
  endfunction

endpackage

// File: rtl/fir_coef_regfile.sv
// fir_coef_regfile: NTAPS x CWIDTH coefficient store, synchronous write, combinational indexed read.
// Latency: write visible on rd_data the cycle after wr_en; read is zero-cycle.
// Backpressure: none; the parent gates wr_en (writes are only allowed while the engine is idle).
// Ports: clk/rst (sync, active-high), wr_en/wr_addr/wr_data write port,
//        rd_addr/rd_data tap-indexed read port.
`timescale 1ns/1ps
module fir_coef_regfile #(
  parameter int CWIDTH = 8,
  parameter int NTAPS  = 4,
  localparam int TWIDTH = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [TWIDTH-1:0] wr_addr,
  input  logic [CWIDTH-1:0] wr_data,
  input  logic [TWIDTH-1:0] rd_addr,
  output logic [CWIDTH-1:0] rd_data
);

  logic [CWIDTH-1:0] coef [NTAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        coef[i] <= '0;
      end
    end else if (wr_en && (int'(wr_addr) < NTAPS)) begin
      // Out-of-range indices (non power-of-two NTAPS) are ignored.
      coef[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < NTAPS) begin
      rd_data = coef[rd_addr];
    end
  end

endmodule

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: single-multiplier FIR, pops one FIFO sample, computes y[n] = sum c[k]*x[n-k].
// Latency: out_valid rises NTAPS+2 cycles after the fifo_read_en pulse; one sample per >= NTAPS+4 cycles.
// Backpressure: result held in OUT until out_ready; no FIFO pops and a frozen delay line meanwhile.
// Ports: clk/rst (sync, active-high); fifo_empty_flg/fifo_rdata/fifo_read_en to the sample FIFO;
//        coef_wr_en/coef_addr/coef_wdata coefficient write port (idle only);
//        out_valid/out_ready/out_data result handshake; busy = not idle.
`timescale 1ns/1ps
module fir_serial_mac #(
  parameter int DWIDTH = fir_pkg::DWIDTH,
  parameter int CWIDTH = fir_pkg::CWIDTH,
  parameter int NTAPS  = fir_pkg::NTAPS,
  localparam int AWIDTH = fir_pkg::calc_awidth(DWIDTH, CWIDTH, NTAPS),
  localparam int TWIDTH = $clog2(NTAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty_flg,
  input  logic [DWIDTH-1:0] fifo_rdata,
  output logic              fifo_read_en,
  input  logic              coef_wr_en,
  input  logic [TWIDTH-1:0] coef_addr,
  input  logic [CWIDTH-1:0] coef_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AWIDTH-1:0] out_data,
  output logic              busy
);

  import fir_pkg::*;

  localparam int PWIDTH = DWIDTH + CWIDTH;

  fir_state_e state, state_nxt;

  logic [DWIDTH-1:0]        x_dly [NTAPS];
  logic signed [AWIDTH-1:0] acc;
  logic [TWIDTH-1:0]        tap_cnt;
  logic [CWIDTH-1:0]        coef_rd;
  logic                     coef_we;
  logic                     last_tap;
  logic [DWIDTH-1:0]        x_sel;
  logic [PWIDTH-1:0]        x_ext;
  logic [PWIDTH-1:0]        c_ext;
  logic signed [PWIDTH-1:0] prod;
  logic signed [AWIDTH-1:0] acc_sum;

  // Coefficients may only change while no computation is using them.
  assign coef_we = coef_wr_en && (state == IDLE);

  fir_coef_regfile #(
    .CWIDTH (CWIDTH),
    .NTAPS  (NTAPS)
  ) u_coef (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (coef_we),
    .wr_addr (coef_addr),
    .wr_data (coef_wdata),
    .rd_addr (tap_cnt),
    .rd_data (coef_rd)
  );

  assign last_tap = (tap_cnt == TWIDTH'(NTAPS - 1));

  // Operands are sign-extended to the full product width first so the
  // multiply is exact for every signed combination, including -2^(N-1)^2.
  always_comb begin
    x_sel   = x_dly[tap_cnt];
    x_ext   = {{CWIDTH{x_sel[DWIDTH-1]}}, x_sel};
    c_ext   = {{DWIDTH{coef_rd[CWIDTH-1]}}, coef_rd};
    prod    = $signed(x_ext) * $signed(c_ext);
    acc_sum = acc + $signed({{TWIDTH{prod[PWIDTH-1]}}, prod});
  end

  always_comb begin
    state_nxt    = state;
    fifo_read_en = 1'b0;
    out_valid    = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (!fifo_empty_flg) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        fifo_read_en = 1'b1;
        state_nxt    = CAPTURE;
      end
      CAPTURE: begin
        state_nxt = MAC;
      end
      MAC: begin
        if (last_tap) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      tap_cnt  <= '0;
      out_data <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        x_dly[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        CAPTURE: begin
          // fifo_rdata is valid here, one cycle after the FETCH pop.
          x_dly[0] <= fifo_rdata;
          for (int i = 1; i < NTAPS; i++) begin
            x_dly[i] <= x_dly[i-1];
          end
          acc     <= '0;
          tap_cnt <= '0;
        end
        MAC: begin
          acc <= acc_sum;
          if (last_tap) begin
            // Register the final sum directly so OUT presents it next cycle.
            out_data <= acc_sum;
          end else begin
            tap_cnt <= tap_cnt + TWIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
`timescale 1ns/1ps
module tb_fir_serial_mac;

  localparam int DW = 8;
  localparam int CW = 8;
  localparam int NT = 4;
  localparam int AW = 18;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty_flg = 1'b1;
  logic [DW-1:0] fifo_rdata = '0;
  logic          fifo_read_en;
  logic          coef_wr_en = 1'b0;
  logic [TW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_wdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_data;
  logic          busy;

  always #5 clk = ~clk;

  fir_serial_mac #(
    .DWIDTH (DW),
    .CWIDTH (CW),
    .NTAPS  (NT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fifo_empty_flg (fifo_empty_flg),
    .fifo_rdata     (fifo_rdata),
    .fifo_read_en   (fifo_read_en),
    .coef_wr_en     (coef_wr_en),
    .coef_addr      (coef_addr),
    .coef_wdata     (coef_wdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .busy           (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0]        fifo_q [$];
  logic signed [AW-1:0] exp_q  [$];

  int   cyc = 0;
  int   rd_cyc = -100;
  logic prev_valid = 1'b0;
  int   rd_empty_viol = 0;

  typedef struct {
    int                   grp;
    logic [DW-1:0]        samp;
    logic signed [AW-1:0] exp;
  } vec_t;

  vec_t          tbl [11];
  logic [CW-1:0] cset [3][NT];

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Sample FIFO: pop on fifo_read_en, data valid the following cycle.
  always @(posedge clk) begin
    if (fifo_read_en) begin
      if (fifo_empty_flg || fifo_q.size() == 0) begin
        rd_empty_viol++;
      end else begin
        fifo_rdata <= fifo_q.pop_front();
      end
    end
    fifo_empty_flg <= (fifo_q.size() == 0);
  end

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (fifo_read_en) rd_cyc = cyc;
    if (out_valid && !prev_valid) check("latency", cyc - rd_cyc, NT + 2);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got %0d, no result expected", $signed(out_data));
      end else begin
        check("out_data", longint'($signed(out_data)), longint'(exp_q.pop_front()));
      end
    end
    prev_valid = out_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sample(input logic [DW-1:0] s, input logic signed [AW-1:0] e);
    fifo_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic write_coef(input int a, input logic [CW-1:0] v);
    coef_wr_en = 1'b1;
    coef_addr  = TW'(a);
    coef_wdata = v;
    step();
    coef_wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while ((exp_q.size() != 0 || busy || fifo_q.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) fail_now(name);
  endtask

  task automatic wait_read(input string name);
    int k = 0;
    @(negedge clk);
    while (!fifo_read_en && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) fail_now(name);
  endtask

  task automatic setup(input int g);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < NT; k++) write_coef(k, cset[g][k]);
  endtask

  initial begin
    int bad;
    cset[0] = '{8'd1, 8'd2, 8'd3, 8'd4};
    cset[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    cset[2] = '{8'h80, 8'h80, 8'h80, 8'h80};

    tbl[0]  = '{0, 8'd1,   18'sd1};
    tbl[1]  = '{0, 8'd0,   18'sd2};
    tbl[2]  = '{0, 8'd0,   18'sd3};
    tbl[3]  = '{0, 8'd0,   18'sd4};
    tbl[4]  = '{0, 8'd0,   18'sd0};
    tbl[5]  = '{1, 8'd127, -18'sd127};
    tbl[6]  = '{1, 8'd127, -18'sd254};
    tbl[7]  = '{2, 8'h80,  18'sd16384};
    tbl[8]  = '{2, 8'h80,  18'sd32768};
    tbl[9]  = '{2, 8'h80,  18'sd49152};
    tbl[10] = '{2, 8'h80,  18'h10000};

    // Reset state.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_read_en", fifo_read_en, 0);
    check("rst_out_data", out_data, 0);

    // Empty FIFO: engine must stay idle.
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fifo_read_en || busy) bad++;
    end
    check("empty_idle", bad, 0);

    // Table-driven filter vectors.
    for (int i = 0; i < 11; i++) begin
      if (i == 0 || tbl[i].grp != tbl[i-1].grp) setup(tbl[i].grp);
      push_sample(tbl[i].samp, tbl[i].exp);
      wait_drain("table_drain");
    end

    // Reset during MAC aborts the popped sample and clears coefficients.
    fifo_q.push_back(8'h80);
    wait_read("abort_read");
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_out_data", out_data, 0);
    push_sample(8'd5, 18'sd0);
    wait_drain("abort_drain");

    // Coefficient write during MAC is dropped.
    setup(0);
    push_sample(8'd1, 18'sd1);
    wait_read("drop_read");
    step();
    step();
    write_coef(0, 8'd9);
    wait_drain("drop_drain");
    for (int i = 2; i <= 4; i++) begin
      push_sample(8'd0, AW'(i));
      wait_drain("shift_drain");
    end

    // Write in IDLE on the same cycle as the IDLE->FETCH transition is kept.
    push_sample(8'd1, 18'sd9);
    step();
    write_coef(0, 8'd9);
    wait_drain("idle_write_drain");

    // Backpressure: result held, no pops until the handshake.
    out_ready = 1'b0;
    push_sample(8'd2, 18'sd20);
    push_sample(8'd0, 18'sd7);
    begin
      int k = 0;
      @(negedge clk);
      while (!out_valid && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (k >= 50) fail_now("bp_wait_valid");
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, 20);
      check("bp_read_en", fifo_read_en, 0);
      @(negedge clk);
    end
    check("bp_no_pop", fifo_q.size(), 1);
    step();
    out_ready = 1'b1;
    wait_drain("bp_drain");

    check("rd_when_empty", rd_empty_viol, 0);
    check("exp_q_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
